// File: rtl/color_reducer.sv
// RGB888 -> RGB444 pixel-stream reducer: one register stage, per-channel rounding
// with saturation. Define COLOR_REDUCER_DITHER_EN for 2x2 ordered dither bias.
module color_reducer #(
    parameter bit SWITCH_RBG_TO_RGB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [11:0] m_data,
    output logic        m_sof,
    output logic        m_eol
);

    // Handshake: a beat moves on any edge where valid && ready; the producer
    // holds data stable while valid is high and ready is low.
    logic       accept;
    logic [7:0] r8, g8, b8;
    logic       x_par, y_par;
    logic       px, py;
    logic [3:0] bias;

    assign s_ready = !rst && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    always_comb begin
        r8 = s_data[23:16];
        if (SWITCH_RBG_TO_RGB) begin
            b8 = s_data[15:8];
            g8 = s_data[7:0];
        end else begin
            g8 = s_data[15:8];
            b8 = s_data[7:0];
        end
    end

    assign px = s_sof ? 1'b0 : x_par;
    assign py = s_sof ? 1'b0 : y_par;

    always_comb begin
`ifdef COLOR_REDUCER_DITHER_EN
        case ({py, px})
            2'b00:   bias = 4'd0;
            2'b01:   bias = 4'd8;
            2'b10:   bias = 4'd12;
            default: bias = 4'd4;
        endcase
`else
        bias = 4'd8;
`endif
    end

    // Carry out of the 9-bit sum means the rounded value would exceed 4'hF.
    function automatic logic [3:0] reduce(input logic [7:0] c, input logic [3:0] t);
        logic [8:0] sum;
        sum = {1'b0, c} + {5'b0, t};
        return sum[8] ? 4'hF : sum[7:4];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 12'h000;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            x_par   <= 1'b0;
            y_par   <= 1'b0;
        end else begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= {reduce(r8, bias), reduce(g8, bias), reduce(b8, bias)};
                m_sof   <= s_sof;
                m_eol   <= s_eol;
                if (s_eol) begin
                    x_par <= 1'b0;
                    y_par <= ~py;
                end else begin
                    x_par <= ~px;
                    y_par <= py;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_color_reducer.sv
// Bench for color_reducer: directed vector table, backpressure, random stream
// against a reference model, and mid-line reset recovery.
module tb_color_reducer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = 24'h0;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [11:0] m_data;
    logic        m_sof;
    logic        m_eol;

    int errors = 0;
    int checks = 0;

    logic [13:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        mx = 1'b0, my = 1'b0;

    color_reducer #(.SWITCH_RBG_TO_RGB(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] bayer(input logic y, input logic x);
`ifdef COLOR_REDUCER_DITHER_EN
        if (!y && !x) return 4'd0;
        if (!y && x)  return 4'd8;
        if (y && !x)  return 4'd12;
        return 4'd4;
`else
        return 4'd8;
`endif
    endfunction

    function automatic logic [3:0] chan(input logic [7:0] c, input logic [3:0] t);
        int v;
        v = (int'(c) + int'(t)) / 16;
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    // Input is {R,B,G}; output is {R,G,B}.
    function automatic logic [11:0] model_px(input logic [23:0] d, input logic [3:0] t);
        return {chan(d[23:16], t), chan(d[7:0], t), chan(d[15:8], t)};
    endfunction

    function automatic logic [23:0] ramp(input int k);
        return {8'(k * 16), 8'(k * 16 + 8), 8'(255 - k * 16)};
    endfunction

    always @(negedge clk) begin
        logic ppx, ppy;
        logic [13:0] e;
        if (mon_en && !rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL stream_extra: got %h expected none", {m_sof, m_eol, m_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("stream", {18'h0, m_sof, m_eol, m_data}, {18'h0, e});
                end
            end
            if (s_valid && s_ready) begin
                ppx = s_sof ? 1'b0 : mx;
                ppy = s_sof ? 1'b0 : my;
                exp_q.push_back({s_sof, s_eol, model_px(s_data, bayer(ppy, ppx))});
                if (s_eol) begin
                    mx = 1'b0;
                    my = ~ppy;
                end else begin
                    mx = ~ppx;
                    my = ppy;
                end
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic sof, input logic eol);
        bit done;
        done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (rnd_mode) m_ready = ($urandom_range(0, 3) != 0);
        end
        if (!done) chk("send_timeout", 32'd1, 32'd0);
        s_valid = 1'b0;
    endtask

    typedef struct {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic [11:0] exp_nd;
        logic [11:0] exp_d;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [11:0] held;
        logic [11:0] want;

        vecs[0]  = '{24'hF04087, 1'b1, 1'b0, 12'hF84, 12'hF84};
        vecs[1]  = '{24'hFFFFFF, 1'b0, 1'b0, 12'hFFF, 12'hFFF};
        vecs[2]  = '{24'h000000, 1'b0, 1'b1, 12'h000, 12'h000};
        vecs[3]  = '{24'h070F08, 1'b0, 1'b0, 12'h011, 12'h111};
        vecs[4]  = '{24'hF8F4FC, 1'b1, 1'b1, 12'hFFF, 12'hFFF};
        vecs[5]  = '{24'h747A76, 1'b0, 1'b0, 12'h778, 12'h888};
        vecs[6]  = '{24'h1B3B5B, 1'b0, 1'b1, 12'h264, 12'h153};
        vecs[7]  = '{24'h787878, 1'b0, 1'b0, 12'h888, 12'h777};
        vecs[8]  = '{24'h787878, 1'b0, 1'b0, 12'h888, 12'h888};
        vecs[9]  = '{24'h787878, 1'b1, 1'b0, 12'h888, 12'h777};
        vecs[10] = '{24'h787878, 1'b0, 1'b1, 12'h888, 12'h888};
        vecs[11] = '{24'h787878, 1'b0, 1'b0, 12'h888, 12'h888};
        vecs[12] = '{24'h787878, 1'b0, 1'b1, 12'h888, 12'h777};

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rst_m_data", {20'h0, m_data}, 32'h0);
        chk("rst_m_sof_eol", {30'h0, m_sof, m_eol}, 32'd0);
        chk("rst_s_ready_after", {31'h0, s_ready}, 32'd1);

        // Directed table, streamed back-to-back
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            s_valid = 1'b1;
            s_data  = vecs[i].data;
            s_sof   = vecs[i].sof;
            s_eol   = vecs[i].eol;
            @(posedge clk);
            #1;
`ifdef COLOR_REDUCER_DITHER_EN
            want = vecs[i].exp_d;
`else
            want = vecs[i].exp_nd;
`endif
            chk($sformatf("vec%0d_valid", i), {31'h0, m_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), {20'h0, m_data}, {20'h0, want});
            chk($sformatf("vec%0d_flags", i), {30'h0, m_sof, m_eol}, {30'h0, vecs[i].sof, vecs[i].eol});
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid_clear", {31'h0, m_valid}, 32'd0);

        // Backpressure: one beat taken, then stall with output held
        mon_en  = 1'b1;
        m_ready = 1'b0;
        send(ramp(0), 1'b1, 1'b0);
        held = model_px(ramp(0), bayer(1'b0, 1'b0));
        s_valid = 1'b1;
        s_data  = ramp(1);
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_s_ready", {31'h0, s_ready}, 32'd0);
            chk("stall_m_data", {20'h0, m_data}, {20'h0, held});
            chk("stall_m_valid", {31'h0, m_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        for (int k = 1; k < 16; k++) send(ramp(k), 1'b0, (k % 4) == 3);
        repeat (3) @(posedge clk);
        #1;
        chk("ramp_drain", exp_q.size(), 32'd0);

        // Random valid/ready stream against the model
        rnd_mode = 1'b1;
        for (int b = 0; b < 10000; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                m_ready = ($urandom_range(0, 3) != 0);
            end
            send(24'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
        end
        rnd_mode = 1'b0;
        m_ready  = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        chk("random_drain", exp_q.size(), 32'd0);
        mon_en = 1'b0;

        // Reset mid-line with an output in flight
        m_ready = 1'b0;
        send(24'h505050, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, m_valid}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("midrst_s_ready", {31'h0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'h787878;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
`ifdef COLOR_REDUCER_DITHER_EN
        want = 12'h777;
`else
        want = 12'h888;
`endif
        chk("postrst_valid", {31'h0, m_valid}, 32'd1);
        chk("postrst_data", {20'h0, m_data}, {20'h0, want});
        @(posedge clk);
        #1;
        chk("postrst_drain", {31'h0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
